// File: rtl/peripheral_motion_ctrl_nch.sv
// Memory-mapped step/dir motion controller with NCH independent channels.
// Each channel emits a programmed number of step pulses at a programmed period on a shared tick.
module peripheral_motion_ctrl_nch #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PRESC  = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       d_in,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  output logic [15:0]       d_out,
  output logic [NCH-1:0]    step,
  output logic [NCH-1:0]    dir,
  output logic              irq
);

  localparam int unsigned ChW = ADDR_W - 2;
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPeriod = 2'd1;
  localparam logic [1:0] RegSteps  = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  logic [15:0]           presc_q;
  logic                  tick;
  logic [ChW-1:0]        sel_ch;
  logic [1:0]            sel_reg;
  logic                  wr_en;
  logic                  rd_en;
  logic [NCH-1:0][15:0]  rd_data;
  logic [NCH-1:0]        done_vec;
  logic [15:0]           rd_mux;

  assign tick    = (presc_q == 16'(PRESC - 1));
  assign sel_ch  = addr[ADDR_W-1:2];
  assign sel_reg = addr[1:0];
  assign wr_en   = cs & wr;
  assign rd_en   = cs & rd;

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e      state_q, state_d;
    logic        sel, wr_ctrl, wr_period, wr_steps, rd_status;
    logic        start, stop, start_run, step_done, done_set;
    logic        ctrl_dir_q, dir_lat_q, done_r, abort_r;
    logic        ch_step, ch_busy, phase_end;
    logic [15:0] period_q, period_lat_q, steps_q, cnt_q;
    logic [15:0] half, low_len, phase_len;
    logic [15:0] ch_rd;

    assign sel       = (sel_ch == ChW'(i));
    assign wr_ctrl   = wr_en & sel & (sel_reg == RegCtrl);
    assign wr_period = wr_en & sel & (sel_reg == RegPeriod);
    assign wr_steps  = wr_en & sel & (sel_reg == RegSteps);
    assign rd_status = rd_en & sel & (sel_reg == RegStatus);
    // Stop has priority over start within one CTRL write.
    assign stop      = wr_ctrl & d_in[2];
    assign start     = wr_ctrl & d_in[0] & ~d_in[2];
    assign start_run = start & (state_q == StIdle) & (steps_q != 16'd0);

    assign half      = {1'b0, period_lat_q[15:1]};
    assign low_len   = period_lat_q - half;
    assign phase_len = (state_q == StHigh) ? half : low_len;
    assign phase_end = tick & ch_busy & ((cnt_q + 16'd1) == phase_len);
    assign step_done = (state_q == StLow) & phase_end & ~stop;
    assign done_set  = (step_done & (steps_q == 16'd1))
                     | (start & (state_q == StIdle) & (steps_q == 16'd0));

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdle;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        StIdle:  if (start_run) state_d = StHigh;
        StHigh:  if (phase_end) state_d = StLow;
        StLow:   if (phase_end) state_d = (steps_q == 16'd1) ? StIdle : StHigh;
        default: state_d = StIdle;
      endcase
      if (stop) state_d = StIdle;
    end

    always_comb begin
      ch_step = (state_q == StHigh);
      ch_busy = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ctrl_dir_q   <= 1'b0;
        dir_lat_q    <= 1'b0;
        period_q     <= 16'd2;
        period_lat_q <= 16'd2;
        steps_q      <= '0;
        cnt_q        <= '0;
        done_r       <= 1'b0;
        abort_r      <= 1'b0;
      end else begin
        if (wr_ctrl) ctrl_dir_q <= d_in[1];
        if (wr_period) period_q <= (d_in < 16'd2) ? 16'd2 : d_in;
        if (start_run) begin
          dir_lat_q    <= d_in[1];
          period_lat_q <= period_q;
          cnt_q        <= '0;
        end else if (ch_busy && tick) begin
          cnt_q <= phase_end ? 16'd0 : cnt_q + 16'd1;
        end
        // Remaining count is owned by the run while busy.
        if (wr_steps && !ch_busy) begin
          steps_q <= d_in;
        end else if (step_done) begin
          steps_q <= steps_q - 16'd1;
        end
        done_r  <= done_set | (done_r & ~rd_status);
        abort_r <= stop | (abort_r & ~rd_status);
      end
    end

    always_comb begin
      case (sel_reg)
        RegCtrl:   ch_rd = {15'b0, ctrl_dir_q};
        RegPeriod: ch_rd = period_q;
        RegSteps:  ch_rd = steps_q;
        default:   ch_rd = {13'b0, abort_r, done_r, ch_busy};
      endcase
    end

    assign rd_data[i]  = ch_rd;
    assign done_vec[i] = done_r;
    assign step[i]     = ch_step;
    assign dir[i]      = dir_lat_q;
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (sel_ch == ChW'(k)) rd_mux = rd_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
      irq   <= 1'b0;
    end else begin
      if (rd_en) d_out <= rd_mux;
      irq <= |done_vec;
    end
  end

endmodule

// File: tb/tb_peripheral_motion_ctrl_nch.sv
// Directed bench for peripheral_motion_ctrl_nch with PRESC=1, NCH=2.
module tb_peripheral_motion_ctrl_nch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [3:0]  addr;
  logic [15:0] d_out;
  logic [1:0]  step, dir;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  peripheral_motion_ctrl_nch #(
    .NCH    (2),
    .ADDR_W (4),
    .PRESC  (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out),
    .step  (step),
    .dir   (dir),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input int ch, input int r, input logic [15:0] v);
    cs = 1'b1; wr = 1'b1; addr = 4'(ch * 4 + r); d_in = v;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input int ch, input int r, output logic [15:0] v);
    cs = 1'b1; rd = 1'b1; addr = 4'(ch * 4 + r);
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0;
    v = d_out;
  endtask

  logic [15:0] rv, tr0, tr1;
  logic        any_step;

  initial begin
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    tick_clk(2);
    rst = 1'b0;

    // Reset state
    check("rst_d_out", d_out, 16'h0000);
    check("rst_step", {14'b0, step}, 16'h0000);
    check("rst_dir", {14'b0, dir}, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0000);
    bus_rd(0, 1, rv); check("rst_period", rv, 16'd2);
    bus_rd(0, 2, rv); check("rst_steps", rv, 16'd0);
    bus_rd(0, 3, rv); check("rst_status", rv, 16'h0000);

    // 1: basic run, 3 pulses of 2 high / 2 low
    bus_wr(0, 1, 16'd4);
    bus_wr(0, 2, 16'd3);
    bus_wr(0, 0, 16'h0001);
    tr0 = '0;
    for (int k = 0; k < 13; k++) begin
      tr0[k] = step[0];
      tick_clk(1);
    end
    check("t1_step_trace", tr0, 16'h0333);
    check("t1_dir", {15'b0, dir[0]}, 16'h0000);
    check("t1_irq_set", {15'b0, irq}, 16'h0001);
    bus_rd(0, 3, rv); check("t1_status_done", rv, 16'h0002);
    bus_rd(0, 3, rv); check("t1_status_clr", rv, 16'h0000);
    check("t1_irq_clr", {15'b0, irq}, 16'h0000);
    bus_rd(0, 2, rv); check("t1_steps_left", rv, 16'd0);

    // 2: ch1 period 6 dir 1 alongside ch0 period 4
    bus_wr(0, 2, 16'd3);
    bus_wr(1, 1, 16'd6);
    bus_wr(1, 2, 16'd2);
    bus_wr(1, 0, 16'h0003);
    bus_wr(0, 0, 16'h0001);
    tr0 = '0; tr1 = '0;
    for (int k = 0; k < 13; k++) begin
      tr0[k] = step[0];
      tr1[k] = step[1];
      tick_clk(1);
    end
    check("t2_ch0_trace", tr0, 16'h0333);
    check("t2_ch1_trace", tr1, 16'h00e3);
    check("t2_dir", {14'b0, dir}, 16'h0002);
    bus_rd(1, 3, rv); check("t2_ch1_status", rv, 16'h0002);
    bus_rd(0, 3, rv); check("t2_ch0_status", rv, 16'h0002);

    // 3: abort after two completed steps
    bus_wr(0, 2, 16'd10);
    bus_wr(0, 0, 16'h0001);
    tick_clk(8);
    check("t3_step_pre", {15'b0, step[0]}, 16'h0001);
    bus_wr(0, 0, 16'h0004);
    check("t3_step_off", {15'b0, step[0]}, 16'h0000);
    bus_rd(0, 2, rv); check("t3_steps_frozen", rv, 16'd8);
    bus_rd(0, 3, rv); check("t3_status_abort", rv, 16'h0004);
    check("t3_irq", {15'b0, irq}, 16'h0000);

    // 4: edge values
    bus_wr(0, 2, 16'd0);
    bus_wr(0, 0, 16'h0001);
    any_step = 1'b0;
    for (int k = 0; k < 4; k++) begin
      any_step |= step[0];
      tick_clk(1);
    end
    check("t4_no_pulse", {15'b0, any_step}, 16'h0000);
    bus_rd(0, 3, rv); check("t4_zero_done", rv, 16'h0002);
    bus_wr(0, 1, 16'd1);
    bus_rd(0, 1, rv); check("t4_period_min", rv, 16'd2);
    bus_wr(0, 1, 16'd4);
    bus_wr(0, 2, 16'd3);
    bus_wr(0, 0, 16'h0001);
    tick_clk(5);
    bus_wr(0, 0, 16'h0001);
    bus_rd(0, 2, rv); check("t4_restart_ignored", rv, 16'd2);
    tick_clk(20);
    bus_rd(0, 3, rv); check("t4_run_done", rv, 16'h0002);
    bus_rd(3, 1, rv); check("t4_bad_channel", rv, 16'h0000);

    // 5: reset mid-motion with irq pending and d_out non-zero
    bus_wr(0, 2, 16'd0);
    bus_wr(0, 0, 16'h0001);
    tick_clk(2);
    check("t5_irq_pre", {15'b0, irq}, 16'h0001);
    bus_wr(1, 1, 16'd8);
    bus_wr(1, 2, 16'd5);
    bus_rd(1, 1, rv); check("t5_period_pre", rv, 16'd8);
    bus_wr(1, 0, 16'h0003);
    check("t5_step_pre", {15'b0, step[1]}, 16'h0001);
    rst = 1'b1;
    tick_clk(1);
    rst = 1'b0;
    check("t5_step", {14'b0, step}, 16'h0000);
    check("t5_dir", {14'b0, dir}, 16'h0000);
    check("t5_irq", {15'b0, irq}, 16'h0000);
    check("t5_d_out", d_out, 16'h0000);
    bus_rd(1, 1, rv); check("t5_period", rv, 16'd2);
    bus_rd(1, 2, rv); check("t5_steps", rv, 16'd0);
    bus_rd(1, 3, rv); check("t5_status", rv, 16'h0000);
    bus_rd(0, 3, rv); check("t5_ch0_status", rv, 16'h0000);

    // 6: bus corner cases
    cs = 1'b0; wr = 1'b1; addr = 4'd1; d_in = 16'd9;
    tick_clk(1);
    wr = 1'b0;
    bus_rd(0, 1, rv); check("t6_cs_low", rv, 16'd2);
    bus_wr(0, 1, 16'd4);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'd1; d_in = 16'd8;
    tick_clk(1);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    check("t6_rdwr_old", d_out, 16'd4);
    bus_rd(0, 1, rv); check("t6_rdwr_new", rv, 16'd8);
    bus_wr(0, 1, 16'd2);
    bus_wr(0, 2, 16'd1);
    bus_wr(0, 0, 16'h0001);
    tick_clk(1);
    bus_rd(0, 3, rv); check("t6_status_race", rv, 16'h0001);
    bus_rd(0, 3, rv); check("t6_done_kept", rv, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
